ncc_peak_finder: RTL and testbench

NCC_PEAK_FINDER -- requirements
Module: ncc_peak_finder

---
 rtl/ncc_peak_finder_if.sv | 36 +++
 rtl/ncc_peak_finder.sv | 125 ++++++++++++
 tb/tb_ncc_peak_finder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ncc_peak_finder_if.sv
// ============================================================================
// ncc_peak_finder_if : accumulator stream and result handshake for the
//                      NCC peak finder.  Rev 1.0
// ============================================================================
`default_nettype none

interface ncc_peak_finder_if #(
  parameter int WIN_W = 16,
  parameter int WIN_H = 16
);
  localparam int XW = $clog2(WIN_W);
  localparam int YW = $clog2(WIN_H);

  logic               start;
  logic               acc_valid;
  logic [15:0][7:0]   acc_in;
  logic               acc_ready;
  logic               result_valid;
  logic               result_ack;
  logic signed [11:0] best_score;
  logic [XW-1:0]      best_x;
  logic [YW-1:0]      best_y;
  logic               busy;

  modport master (
    output start, acc_valid, acc_in, result_ack,
    input  acc_ready, result_valid, best_score, best_x, best_y, busy
  );

  modport slave (
    input  start, acc_valid, acc_in, result_ack,
    output acc_ready, result_valid, best_score, best_x, best_y, busy
  );
endinterface

`default_nettype wire

// File: rtl/ncc_peak_finder.sv
// ============================================================================
// ncc_peak_finder : sums per-row correlation accumulators per window position
//                   and tracks the peak score and position over one scan. Rev 1.0
// ============================================================================
`default_nettype none

module ncc_peak_finder #(
  parameter int WIN_W = 16,
  parameter int WIN_H = 16
) (
  input  logic              clk,
  input  logic              rst,
  ncc_peak_finder_if.slave  bus
);
  localparam int XW = $clog2(WIN_W);
  localparam int YW = $clog2(WIN_H);
  localparam logic [XW-1:0]      X_LAST    = XW'(WIN_W - 1);
  localparam logic [YW-1:0]      Y_LAST    = YW'(WIN_H - 1);
  localparam logic signed [11:0] BEST_INIT = 12'sh800;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_nx;
  logic [XW-1:0]      x_cnt, s1_x, best_x;
  logic [YW-1:0]      y_cnt, s1_y, best_y;
  logic               flush_cnt;
  logic               s1_valid;
  logic signed [11:0] s1_sum, best_score, sum;
  logic               acc_ready, result_valid, busy, accept, last_pos;

  // 16 signed bytes cannot exceed 12 bits, so a plain 12-bit adder chain is exact
  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + {{4{bus.acc_in[i][7]}}, bus.acc_in[i]};
    end
  end

  assign last_pos = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    acc_ready    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nx = SCAN;
      end
      SCAN: begin
        acc_ready = 1'b1;
        accept    = bus.acc_valid;
        if (bus.acc_valid && last_pos) state_nx = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt) state_nx = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (bus.result_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      flush_cnt  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
    end else begin
      s1_valid  <= accept;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;

      if (accept) begin
        s1_sum <= sum;
        s1_x   <= x_cnt;
        s1_y   <= y_cnt;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end

      // strict compare so a tie keeps the earlier position
      if (state == IDLE && bus.start) begin
        x_cnt      <= '0;
        y_cnt      <= '0;
        best_score <= BEST_INIT;
        best_x     <= '0;
        best_y     <= '0;
      end else if (s1_valid && (s1_sum > best_score)) begin
        best_score <= s1_sum;
        best_x     <= s1_x;
        best_y     <= s1_y;
      end
    end
  end

  assign bus.acc_ready    = acc_ready;
  assign bus.result_valid = result_valid;
  assign bus.busy         = busy;
  assign bus.best_score   = best_score;
  assign bus.best_x       = best_x;
  assign bus.best_y       = best_y;

endmodule

`default_nettype wire

// File: tb/tb_ncc_peak_finder.sv
// Bench for ncc_peak_finder: table-driven directed scans, randomized scans
// against a reference model, and reset / held-result sequences.
`default_nettype none

module tb_ncc_peak_finder;
  localparam int W = 4;
  localparam int H = 4;
  localparam int NPOS = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ncc_peak_finder_if #(.WIN_W(W), .WIN_H(H)) bus ();
  ncc_peak_finder #(.WIN_W(W), .WIN_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [7:0] pos_rows [NPOS][16];

  typedef struct {
    int base;
    int px, py, pval;
    int qx, qy, qval;
    int mixed;
    int gaps;
    int es, ex, ey;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_vec(input vec_t v);
    int val;
    for (int p = 0; p < NPOS; p++) begin
      for (int r = 0; r < 16; r++) begin
        val = v.base;
        if (v.mixed != 0) val = (r < 8) ? 127 : -128;
        if (p == v.py * W + v.px) val = v.pval;
        if (p == v.qy * W + v.qx) val = v.qval;
        pos_rows[p][r] = 8'(val);
      end
    end
  endtask

  task automatic fill_random();
    int mode;
    mode = $urandom_range(0, 2);
    for (int p = 0; p < NPOS; p++) begin
      for (int r = 0; r < 16; r++) begin
        case (mode)
          0:       pos_rows[p][r] = 8'($urandom_range(0, 255));
          1:       pos_rows[p][r] = 8'(int'($urandom_range(0, 2)) - 1);
          default: pos_rows[p][r] = 8'(-128 + int'($urandom_range(0, 8)));
        endcase
      end
    end
  endtask

  // Score = plain sum of the rows; first strictly greater position wins, raster order
  task automatic model(output int s, output int bx, output int by);
    int sum;
    s = -2048; bx = 0; by = 0;
    for (int p = 0; p < NPOS; p++) begin
      sum = 0;
      for (int r = 0; r < 16; r++) sum += int'(pos_rows[p][r]);
      if (sum > s) begin
        s = sum; bx = p % W; by = p / W;
      end
    end
  endtask

  task automatic drive_rows(input int p);
    for (int r = 0; r < 16; r++) bus.acc_in[r] = pos_rows[p][r];
  endtask

  task automatic do_scan(input int gaps, input int hold, input int es, input int ex, input int ey);
    int n;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("scan_busy", int'(bus.busy), 1);
    check("scan_ready", int'(bus.acc_ready), 1);
    for (int p = 0; p < NPOS; p++) begin
      n = 0;
      while (gaps != 0 && n < 3 && $urandom_range(0, 1) == 1) begin
        bus.acc_valid = 1'b0;
        for (int r = 0; r < 16; r++) bus.acc_in[r] = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        n++;
      end
      bus.acc_valid  = 1'b1;
      bus.result_ack = (p == 0);
      drive_rows(p);
      @(posedge clk); #1 bus.result_ack = 1'b0;
    end
    // keep offering large samples after the scan; they must be ignored
    for (int r = 0; r < 16; r++) bus.acc_in[r] = 8'sd127;
    check("flush1_valid", int'(bus.result_valid), 0);
    check("flush1_ready", int'(bus.acc_ready), 0);
    @(posedge clk); #1;
    check("flush2_valid", int'(bus.result_valid), 0);
    @(posedge clk); #1;
    check("done_valid", int'(bus.result_valid), 1);
    check("done_ready", int'(bus.acc_ready), 0);
    check("score", int'(bus.best_score), es);
    check("best_x", int'(bus.best_x), ex);
    check("best_y", int'(bus.best_y), ey);
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", int'(bus.result_valid), 1);
      check("hold_score", int'(bus.best_score), es);
      check("hold_xy", int'(bus.best_x) * 16 + int'(bus.best_y), ex * 16 + ey);
    end
    bus.start      = 1'b0;
    bus.result_ack = 1'b1;
    @(posedge clk); #1;
    bus.result_ack = 1'b0;
    bus.acc_valid  = 1'b0;
    check("ack_valid", int'(bus.result_valid), 0);
    check("ack_busy", int'(bus.busy), 0);
    check("idle_score", int'(bus.best_score), es);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, int'(bus.acc_ready), 0);
    check({tag, "_valid"}, int'(bus.result_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_score"}, int'(bus.best_score), 0);
    check({tag, "_x"}, int'(bus.best_x), 0);
    check({tag, "_y"}, int'(bus.best_y), 0);
  endtask

  initial begin
    int ms, mx, my;
    bus.start      = 1'b0;
    bus.acc_valid  = 1'b0;
    bus.result_ack = 1'b0;
    for (int r = 0; r < 16; r++) bus.acc_in[r] = 8'h00;

    // base, peak(x,y,val), second peak(x,y,val), mixed, gaps, expected score/x/y
    vecs[0] = '{1,    2, 1, 3,    2, 1, 3,     0, 0,   48,   2, 1};
    vecs[1] = '{-128, -1, -1, 0,  -1, -1, 0,   0, 0,   -2048, 0, 0};
    vecs[2] = '{0,    1, 0, 100,  3, 3, 100,   0, 0,   1600, 1, 0};
    vecs[3] = '{0,    -1, -1, 0,  -1, -1, 0,   1, 0,   -8,   0, 0};
    vecs[4] = '{1,    2, 1, 3,    2, 1, 3,     0, 1,   48,   2, 1};
    vecs[5] = '{127,  -1, -1, 0,  -1, -1, 0,   0, 1,   2032, 0, 0};
    vecs[6] = '{-5,   3, 3, -4,   -1, -1, 0,   0, 0,   -64,  3, 3};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 7; i++) begin
      fill_vec(vecs[i]);
      do_scan(vecs[i].gaps, 0, vecs[i].es, vecs[i].ex, vecs[i].ey);
    end

    // result withheld for 10 cycles with start asserted during DONE
    fill_vec(vecs[2]);
    do_scan(1, 10, 1600, 1, 0);

    // same random data streamed back-to-back and with gaps must agree with the model
    for (int k = 0; k < 6; k++) begin
      fill_random();
      model(ms, mx, my);
      do_scan(0, 0, ms, mx, my);
      do_scan(1, 0, ms, mx, my);
    end

    // abandon a scan after 7 accepts; reset wins over start/valid/ack on the same edge
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int r = 0; r < 16; r++) bus.acc_in[r] = 8'sd127;
    bus.acc_valid = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.result_ack = 1'b1;
    @(posedge clk); #1;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.result_ack = 1'b0;
    bus.acc_valid  = 1'b0;
    check_reset_state("midreset");
    @(posedge clk); #1;
    check("midreset_score2", int'(bus.best_score), 0);
    fill_vec(vecs[0]);
    do_scan(0, 0, 48, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
